// File: rtl/uart_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_frame_ctrl
//
// Frame-level sequencer sitting between the byte-level uart_rx / uart_tx
// cores and the interface register buffers. Received bytes are assembled
// into a BUFFER_SIZE-bit frame whose top 32 bits must carry MSGID. A valid
// frame is published on rx_data with a one-cycle sync pulse; after a short
// turnaround the reply frame (tx_data, captured at sync) is sent MSB byte
// first through the transmitter's start/busy handshake. A link watchdog,
// an inter-byte gap abort and a saturating frame error counter round it off.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   rx_byte        received byte from uart_rx
//   rx_byte_valid  one-cycle strobe, rx_byte valid
//   rx_eop         end-of-packet strobe from uart_rx
//   tx_byte        byte presented to uart_tx
//   tx_start       one-cycle transmit request
//   tx_busy        transmitter busy
//   tx_data        reply frame, sampled when sync is issued
//   rx_data        last valid received frame
//   sync           one-cycle pulse, rx_data updated
//   pkg_timeout    watchdog expired, sticky until the next valid frame
//   frame_err_cnt  saturating count of aborted or bad-MSGID frames
// ---------------------------------------------------------------------------
module uart_frame_ctrl #(
  parameter int unsigned BUFFER_SIZE = 80,
  parameter logic [31:0] MSGID       = 32'h74697277,
  parameter logic [31:0] TIMEOUT     = 32'd4800000,
  parameter logic [15:0] BYTE_GAP    = 16'd240,
  parameter logic [15:0] TURNAROUND  = 16'd24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_byte_valid,
  input  logic                   rx_eop,
  output logic [7:0]             tx_byte,
  output logic                   tx_start,
  input  logic                   tx_busy,
  input  logic [BUFFER_SIZE-1:0] tx_data,
  output logic [BUFFER_SIZE-1:0] rx_data,
  output logic                   sync,
  output logic                   pkg_timeout,
  output logic [7:0]             frame_err_cnt
);

  localparam int unsigned NBYTES = BUFFER_SIZE / 8;
  localparam int unsigned CNT_W = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] FRAME_BYTES = CNT_W'(NBYTES);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    CHECK,
    WAIT_TA,
    SEND,
    SEND_WAIT
  } state_t;

  state_t                 state, state_n;
  logic [BUFFER_SIZE-1:0] shift_buf, shift_buf_n;
  logic [BUFFER_SIZE-1:0] reply, reply_n;
  logic [CNT_W-1:0]       byte_cnt, byte_cnt_n;
  logic [CNT_W-1:0]       tx_cnt, tx_cnt_n;
  logic [15:0]            gap_cnt, gap_cnt_n;
  logic [15:0]            ta_cnt, ta_cnt_n;
  logic [31:0]            wd_cnt, wd_cnt_n;
  logic                   busy_seen, busy_seen_n;
  logic [7:0]             tx_byte_n;
  logic                   tx_start_n;
  logic [BUFFER_SIZE-1:0] rx_data_n;
  logic                   sync_n;
  logic                   pkg_timeout_n;
  logic [7:0]             frame_err_cnt_n;
  logic [7:0]             err_inc;

  always_comb begin
    state_n         = state;
    shift_buf_n     = shift_buf;
    reply_n         = reply;
    byte_cnt_n      = byte_cnt;
    tx_cnt_n        = tx_cnt;
    gap_cnt_n       = gap_cnt;
    ta_cnt_n        = ta_cnt;
    wd_cnt_n        = wd_cnt;
    busy_seen_n     = busy_seen;
    tx_byte_n       = tx_byte;
    tx_start_n      = 1'b0;
    rx_data_n       = rx_data;
    sync_n          = 1'b0;
    pkg_timeout_n   = pkg_timeout;
    frame_err_cnt_n = frame_err_cnt;
    err_inc         = (frame_err_cnt == 8'hFF) ? 8'hFF : frame_err_cnt + 8'd1;

    // Watchdog runs in every state; a valid frame in CHECK overrides it below.
    if (wd_cnt < TIMEOUT) begin
      wd_cnt_n = wd_cnt + 32'd1;
    end
    if (wd_cnt_n >= TIMEOUT) begin
      pkg_timeout_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (rx_byte_valid) begin
          shift_buf_n = {shift_buf[BUFFER_SIZE-9:0], rx_byte};
          byte_cnt_n  = CNT_W'(1);
          gap_cnt_n   = 16'd0;
          state_n     = RECV;
        end
      end

      RECV: begin
        // A byte arriving together with eop is taken first; eop only aborts
        // when that byte leaves the frame incomplete.
        if (rx_byte_valid) begin
          shift_buf_n = {shift_buf[BUFFER_SIZE-9:0], rx_byte};
          byte_cnt_n  = byte_cnt + CNT_W'(1);
          gap_cnt_n   = 16'd0;
          if (byte_cnt_n == FRAME_BYTES) begin
            state_n = CHECK;
          end else if (rx_eop) begin
            frame_err_cnt_n = err_inc;
            state_n         = IDLE;
          end
        end else if (rx_eop) begin
          frame_err_cnt_n = err_inc;
          state_n         = IDLE;
        end else begin
          if (gap_cnt != 16'hFFFF) begin
            gap_cnt_n = gap_cnt + 16'd1;
          end
          if (gap_cnt_n >= BYTE_GAP) begin
            frame_err_cnt_n = err_inc;
            state_n         = IDLE;
          end
        end
      end

      CHECK: begin
        if (shift_buf[BUFFER_SIZE-1 -: 32] == MSGID) begin
          rx_data_n     = shift_buf;
          sync_n        = 1'b1;
          reply_n       = tx_data;
          wd_cnt_n      = 32'd0;
          pkg_timeout_n = 1'b0;
          ta_cnt_n      = 16'd0;
          state_n       = WAIT_TA;
        end else begin
          frame_err_cnt_n = err_inc;
          state_n         = IDLE;
        end
      end

      WAIT_TA: begin
        // Widened compare so a TURNAROUND of zero cannot underflow.
        if (({1'b0, ta_cnt} + 17'd1) >= {1'b0, TURNAROUND}) begin
          tx_cnt_n = '0;
          state_n  = SEND;
        end else begin
          ta_cnt_n = ta_cnt + 16'd1;
        end
      end

      SEND: begin
        if (!tx_busy) begin
          tx_byte_n   = reply[BUFFER_SIZE-1 -: 8];
          tx_start_n  = 1'b1;
          busy_seen_n = 1'b0;
          state_n     = SEND_WAIT;
        end
      end

      SEND_WAIT: begin
        // A byte is done only after busy has been seen high and then low;
        // if busy never rises we deliberately stay here.
        if (tx_busy) begin
          busy_seen_n = 1'b1;
        end else if (busy_seen) begin
          busy_seen_n = 1'b0;
          reply_n     = {reply[BUFFER_SIZE-9:0], 8'h00};
          tx_cnt_n    = tx_cnt + CNT_W'(1);
          state_n     = (tx_cnt_n == FRAME_BYTES) ? IDLE : SEND;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shift_buf     <= '0;
      reply         <= '0;
      byte_cnt      <= '0;
      tx_cnt        <= '0;
      gap_cnt       <= 16'd0;
      ta_cnt        <= 16'd0;
      wd_cnt        <= 32'd0;
      busy_seen     <= 1'b0;
      tx_byte       <= 8'd0;
      tx_start      <= 1'b0;
      rx_data       <= '0;
      sync          <= 1'b0;
      pkg_timeout   <= 1'b0;
      frame_err_cnt <= 8'd0;
    end else begin
      state         <= state_n;
      shift_buf     <= shift_buf_n;
      reply         <= reply_n;
      byte_cnt      <= byte_cnt_n;
      tx_cnt        <= tx_cnt_n;
      gap_cnt       <= gap_cnt_n;
      ta_cnt        <= ta_cnt_n;
      wd_cnt        <= wd_cnt_n;
      busy_seen     <= busy_seen_n;
      tx_byte       <= tx_byte_n;
      tx_start      <= tx_start_n;
      rx_data       <= rx_data_n;
      sync          <= sync_n;
      pkg_timeout   <= pkg_timeout_n;
      frame_err_cnt <= frame_err_cnt_n;
    end
  end

endmodule
